// File: rtl/seq_load_packer_pkg.sv
// Shared types for the sequential-load packer.
// Commit modes and controller states.
package seq_load_packer_pkg;

   typedef enum logic {
      SEQ_SERIAL = 1'b0,
      SEQ_GATHER = 1'b1
   } seq_mode_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } seq_state_e;

endpackage

// File: rtl/seq_load_packer_if.sv
// Request, R-beat and shuffle-side bundle for the packer.
// master drives requests/beats, slave is the packer.
interface seq_load_packer_if
   import seq_load_packer_pkg::*;
#(
   parameter int unsigned BusNibbles = 16,
   parameter int unsigned BufNibbles = 32,
   parameter int unsigned EewW       = 2
);
   localparam int unsigned PtrW = $clog2(BufNibbles);
   localparam int unsigned LoW  = $clog2(BusNibbles);

   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [PtrW-1:0]         cmd_ptr;
   seq_mode_e               cmd_mode;
   logic [EewW-1:0]         cmd_eew;

   logic                    beat_valid;
   logic                    beat_ready;
   logic [4*BusNibbles-1:0] beat_data;
   logic [LoW-1:0]          beat_lo;
   logic [LoW:0]            beat_hi;
   logic                    beat_last;

   logic                    out_valid;
   logic                    out_ready;
   logic [4*BufNibbles-1:0] out_data;
   logic [BufNibbles-1:0]   out_en;
   logic                    out_last;

   modport master (
      output cmd_valid, cmd_ptr, cmd_mode, cmd_eew,
      output beat_valid, beat_data, beat_lo,
      output beat_hi, beat_last, out_ready,
      input  cmd_ready, beat_ready, out_valid,
      input  out_data, out_en, out_last
   );

   modport slave (
      input  cmd_valid, cmd_ptr, cmd_mode, cmd_eew,
      input  beat_valid, beat_data, beat_lo,
      input  beat_hi, beat_last, out_ready,
      output cmd_ready, beat_ready, out_valid,
      output out_data, out_en, out_last
   );

endinterface

// File: rtl/seq_entry_fifo.sv
// Entry FIFO; the tail slot doubles as the working entry
// that is filled nibble-by-nibble before being pushed.
module seq_entry_fifo #(
   parameter int unsigned BufNibbles = 32,
   parameter int unsigned BufDepth   = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [BufNibbles-1:0]       wr_mask_i,
   input  logic [BufNibbles-1:0][3:0]  wr_data_i,
   input  logic                        push_i,
   input  logic                        push_last_i,
   input  logic                        pop_i,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [4*BufNibbles-1:0]     head_nb_o,
   output logic [BufNibbles-1:0]       head_en_o,
   output logic                        head_last_o
);
   localparam int unsigned IdxW = $clog2(BufDepth);

   typedef struct packed {
      logic [BufNibbles-1:0][3:0] nb;
      logic [BufNibbles-1:0]      en;
      logic                       last;
   } seq_entry_t;

   seq_entry_t      mem_q [BufDepth];
   seq_entry_t      mem_d [BufDepth];
   logic [IdxW:0]   wr_q, wr_d;
   logic [IdxW:0]   rd_q, rd_d;
   logic [IdxW-1:0] wr_idx, rd_idx;
   seq_entry_t      head;

   assign wr_idx  = wr_q[IdxW-1:0];
   assign rd_idx  = rd_q[IdxW-1:0];
   assign full_o  = (wr_idx == rd_idx) && (wr_q[IdxW] != rd_q[IdxW]);
   assign empty_o = (wr_idx == rd_idx) && (wr_q[IdxW] == rd_q[IdxW]);

   // Head is hidden while empty so a half-built entry never shows.
   assign head        = mem_q[rd_idx];
   assign head_nb_o   = empty_o ? '0 : head.nb;
   assign head_en_o   = empty_o ? '0 : head.en;
   assign head_last_o = empty_o ? 1'b0 : head.last;

   // Masked write into the working slot, push, and clear-on-pop.
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      for (int i = 0; i < BufNibbles; i++) begin
         if (wr_mask_i[i]) begin
            mem_d[wr_idx].nb[i] = wr_data_i[i];
            mem_d[wr_idx].en[i] = 1'b1;
         end
      end
      if (push_i) begin
         mem_d[wr_idx].last = push_last_i;
         wr_d = wr_q + 1'b1;
      end
      if (pop_i) begin
         mem_d[rd_idx] = '0;
         rd_d = rd_q + 1'b1;
      end
   end

   // Storage and flagged pointers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < BufDepth; i++) mem_q[i] <= '0;
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         for (int i = 0; i < BufDepth; i++) mem_q[i] <= mem_d[i];
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

endmodule

// File: rtl/seq_load_packer.sv
// Packs valid R-beat nibbles into lane entries, serial or
// gather, splitting beats that straddle an entry boundary.
module seq_load_packer
   import seq_load_packer_pkg::*;
#(
   parameter int unsigned BusNibbles = 16,
   parameter int unsigned BufNibbles = 32,
   parameter int unsigned BufDepth   = 2,
   parameter int unsigned EewW       = 2
) (
   input logic               clk_i,
   input logic               rst_ni,
   seq_load_packer_if.slave  bus
);
   localparam int unsigned AW   = $clog2(BufNibbles) + 1;
   localparam int unsigned PtrW = AW - 1;
   localparam int unsigned LoW  = $clog2(BusNibbles);

   seq_state_e      state_q, state_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   bus_cnt_q, bus_cnt_d;
   seq_mode_e       mode_q, mode_d;
   logic [EewW-1:0] eew_q, eew_d;

   logic [AW-1:0]   lo_w, hi_w, ptr_w, elem_w;
   logic [AW-1:0]   span, room, n, end_w, src_base;
   logic            split, full, empty, commit;
   logic            push, push_last, pop;
   logic            cmd_ready, beat_ready;

   logic [BufNibbles-1:0]      wr_mask;
   logic [BufNibbles-1:0][3:0] wr_data;

   // Span, room and the number of nibbles taken this cycle.
   always_comb begin
      lo_w     = AW'(bus.beat_lo);
      hi_w     = AW'(bus.beat_hi);
      ptr_w    = AW'(wr_ptr_q);
      elem_w   = AW'(1) << eew_q;
      span     = (mode_q == SEQ_GATHER) ? elem_w - bus_cnt_q
                                        : hi_w - lo_w - bus_cnt_q;
      room     = AW'(BufNibbles) - ptr_w;
      split    = span > room;
      n        = split ? room : span;
      end_w    = ptr_w + n;
      src_base = lo_w + bus_cnt_q;
      commit   = (state_q == S_RUN) && bus.beat_valid && !full;
   end

   // Nibble crossbar: slot s takes beat nibble base+(s-ptr).
   always_comb begin
      logic [AW-1:0]           s_w, src;
      logic [4*BusNibbles-1:0] sh;
      wr_mask = '0;
      wr_data = '0;
      s_w     = '0;
      src     = '0;
      sh      = '0;
      for (int s = 0; s < BufNibbles; s++) begin
         s_w        = AW'(s);
         src        = src_base + s_w - ptr_w;
         sh         = bus.beat_data >> {src[LoW-1:0], 2'b00};
         wr_data[s] = sh[3:0];
         wr_mask[s] = commit && (s_w >= ptr_w) && (s_w < end_w);
      end
   end

   // Controller next state, pointer updates and push decision.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      bus_cnt_d  = bus_cnt_q;
      mode_d     = mode_q;
      eew_d      = eew_q;
      push       = 1'b0;
      push_last  = 1'b0;
      cmd_ready  = (state_q == S_IDLE);
      beat_ready = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               state_d   = S_RUN;
               wr_ptr_d  = bus.cmd_ptr;
               bus_cnt_d = '0;
               mode_d    = bus.cmd_mode;
               eew_d     = bus.cmd_eew;
            end
         end
         S_RUN: begin
            beat_ready = !full && !split;
            if (commit) begin
               if (split) begin
                  push      = 1'b1;
                  wr_ptr_d  = '0;
                  bus_cnt_d = bus_cnt_q + n;
               end else begin
                  bus_cnt_d = '0;
                  wr_ptr_d  = end_w[PtrW-1:0];
                  if (end_w == AW'(BufNibbles) || bus.beat_last) begin
                     push      = 1'b1;
                     push_last = bus.beat_last;
                     wr_ptr_d  = '0;
                  end
                  if (bus.beat_last) state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Controller registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         bus_cnt_q <= '0;
         mode_q    <= SEQ_SERIAL;
         eew_q     <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         bus_cnt_q <= bus_cnt_d;
         mode_q    <= mode_d;
         eew_q     <= eew_d;
      end
   end

   assign pop = !empty && bus.out_ready;

   seq_entry_fifo #(
      .BufNibbles (BufNibbles),
      .BufDepth   (BufDepth)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .wr_mask_i   (wr_mask),
      .wr_data_i   (wr_data),
      .push_i      (push),
      .push_last_i (push_last),
      .pop_i       (pop),
      .full_o      (full),
      .empty_o     (empty),
      .head_nb_o   (bus.out_data),
      .head_en_o   (bus.out_en),
      .head_last_o (bus.out_last)
   );

   assign bus.cmd_ready  = cmd_ready;
   assign bus.beat_ready = beat_ready;
   assign bus.out_valid  = !empty;

endmodule

// File: tb/tb_seq_load_packer.sv
// Directed bench for seq_load_packer.
// Inputs change at negedge, outputs are checked 1 time unit later.
module tb_seq_load_packer;
   import seq_load_packer_pkg::*;

   logic clk;
   logic rst_n;
   int   errs;
   int   checks;

   seq_load_packer_if #(
      .BusNibbles (16),
      .BufNibbles (32),
      .EewW       (2)
   ) bus ();

   seq_load_packer #(
      .BusNibbles (16),
      .BufNibbles (32),
      .BufDepth   (2),
      .EewW       (2)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [63:0] D0 = 64'hFEDCBA9876543210;
   localparam logic [63:0] D1 = 64'h0123456789ABCDEF;

   task automatic start_cmd(input int ptr, input seq_mode_e mode,
                            input int eew);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_ptr   = 5'(ptr);
      bus.cmd_mode  = mode;
      bus.cmd_eew   = 2'(eew);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic drive_beat(input logic [63:0] d, input int lo,
                             input int hi, input bit last);
      bus.beat_valid = 1'b1;
      bus.beat_data  = d;
      bus.beat_lo    = 4'(lo);
      bus.beat_hi    = 5'(hi);
      bus.beat_last  = last;
   endtask

   task automatic idle_beat();
      bus.beat_valid = 1'b0;
      bus.beat_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_ptr   = '0;
      bus.cmd_mode  = SEQ_SERIAL;
      bus.cmd_eew   = '0;
      bus.beat_data = '0;
      bus.beat_lo   = '0;
      bus.beat_hi   = '0;
      bus.out_ready = 1'b0;
      idle_beat();
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errs++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready);
      end
      checks++;
      if (bus.beat_ready !== 1'b0) begin
         errs++; $display("FAIL rst_beat_ready got=%b exp=0", bus.beat_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errs++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid);
      end
      checks++;
      if (bus.out_data !== '0 || bus.out_en !== '0 || bus.out_last !== 1'b0) begin
         errs++; $display("FAIL rst_out got=%h/%h/%b exp=0",
                          bus.out_data, bus.out_en, bus.out_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errs++; $display("FAIL rel_cmd_ready got=%b exp=1", bus.cmd_ready);
      end
   endtask

   task automatic test_serial();
      start_cmd(0, SEQ_SERIAL, 0);
      @(negedge clk);
      drive_beat(D0, 0, 16, 1'b0);
      #1;
      checks++;
      if (bus.beat_ready !== 1'b1) begin
         errs++; $display("FAIL ser_rdy0 got=%b exp=1", bus.beat_ready);
      end
      @(negedge clk);
      drive_beat(D1, 0, 16, 1'b1);
      #1;
      checks++;
      if (bus.beat_ready !== 1'b1) begin
         errs++; $display("FAIL ser_rdy1 got=%b exp=1", bus.beat_ready);
      end
      @(negedge clk);
      idle_beat();
      #1;
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errs++; $display("FAIL ser_valid got=%b exp=1", bus.out_valid);
      end
      checks++;
      if (bus.out_data !== {D1, D0}) begin
         errs++; $display("FAIL ser_data got=%h exp=%h", bus.out_data, {D1, D0});
      end
      checks++;
      if (bus.out_en !== 32'hFFFFFFFF || bus.out_last !== 1'b1) begin
         errs++; $display("FAIL ser_en_last got=%h/%b exp=ffffffff/1",
                          bus.out_en, bus.out_last);
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errs++; $display("FAIL ser_idle got=%b exp=1", bus.cmd_ready);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errs++; $display("FAIL ser_drain got=%b exp=0", bus.out_valid);
      end
   endtask

   task automatic test_split();
      start_cmd(24, SEQ_SERIAL, 0);
      @(negedge clk);
      drive_beat(D0, 4, 16, 1'b1);
      #1;
      checks++;
      if (bus.beat_ready !== 1'b0) begin
         errs++; $display("FAIL split_rdy_a got=%b exp=0", bus.beat_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.beat_ready !== 1'b1) begin
         errs++; $display("FAIL split_rdy_b got=%b exp=1", bus.beat_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== {32'hBA987654, 96'h0}) begin
         errs++; $display("FAIL split_e0_data got=%b/%h exp=1/%h",
                          bus.out_valid, bus.out_data, {32'hBA987654, 96'h0});
      end
      checks++;
      if (bus.out_en !== 32'hFF000000 || bus.out_last !== 1'b0) begin
         errs++; $display("FAIL split_e0_en got=%h/%b exp=ff000000/0",
                          bus.out_en, bus.out_last);
      end
      @(negedge clk);
      idle_beat();
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.out_en !== 32'hFF000000) begin
         errs++; $display("FAIL split_hold got=%b/%h exp=1/ff000000",
                          bus.cmd_ready, bus.out_en);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_data !== {112'h0, 16'hFEDC}) begin
         errs++; $display("FAIL split_e1_data got=%h exp=%h",
                          bus.out_data, {112'h0, 16'hFEDC});
      end
      checks++;
      if (bus.out_en !== 32'h0000000F || bus.out_last !== 1'b1) begin
         errs++; $display("FAIL split_e1_en got=%h/%b exp=0000000f/1",
                          bus.out_en, bus.out_last);
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errs++; $display("FAIL split_drain got=%b exp=0", bus.out_valid);
      end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      start_cmd(0, SEQ_SERIAL, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive_beat({16{4'(k + 1)}}, 0, 16, 1'b0);
         #1;
         checks++;
         if (bus.beat_ready !== 1'b1) begin
            errs++; $display("FAIL bp_rdy%0d got=%b exp=1", k, bus.beat_ready);
         end
      end
      @(negedge clk);
      drive_beat({16{4'h5}}, 0, 16, 1'b1);
      #1;
      checks++;
      if (bus.beat_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
         errs++; $display("FAIL bp_block0 got=%b/%b exp=0/1",
                          bus.beat_ready, bus.out_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.beat_ready !== 1'b0) begin
         errs++; $display("FAIL bp_block1 got=%b exp=0", bus.beat_ready);
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.beat_ready !== 1'b0) begin
         errs++; $display("FAIL bp_block_rdyhi got=%b exp=0", bus.beat_ready);
      end
      checks++;
      if (bus.out_data !== {{16{4'h2}}, {16{4'h1}}}) begin
         errs++; $display("FAIL bp_entry_a got=%h exp=%h",
                          bus.out_data, {{16{4'h2}}, {16{4'h1}}});
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      checks++;
      if (bus.beat_ready !== 1'b1) begin
         errs++; $display("FAIL bp_resume got=%b exp=1", bus.beat_ready);
      end
      checks++;
      if (bus.out_data !== {{16{4'h4}}, {16{4'h3}}}) begin
         errs++; $display("FAIL bp_entry_b got=%h exp=%h",
                          bus.out_data, {{16{4'h4}}, {16{4'h3}}});
      end
      @(negedge clk);
      idle_beat();
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.out_data !== {{16{4'h4}}, {16{4'h3}}} || bus.cmd_ready !== 1'b1) begin
         errs++; $display("FAIL bp_entry_b_hold got=%h/%b exp=%h/1",
                          bus.out_data, bus.cmd_ready, {{16{4'h4}}, {16{4'h3}}});
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_data !== {64'h0, {16{4'h5}}}) begin
         errs++; $display("FAIL bp_entry_c got=%h exp=%h",
                          bus.out_data, {64'h0, {16{4'h5}}});
      end
      checks++;
      if (bus.out_en !== 32'h0000FFFF || bus.out_last !== 1'b1) begin
         errs++; $display("FAIL bp_entry_c_en got=%h/%b exp=0000ffff/1",
                          bus.out_en, bus.out_last);
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errs++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid);
      end
   endtask

   task automatic test_gather();
      logic [63:0]  d;
      logic [127:0] exp;
      int           lo;
      exp = '0;
      start_cmd(0, SEQ_GATHER, 1);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         for (int j = 0; j < 16; j++) d[4*j +: 4] = 4'((j + k) & 15);
         lo = (2 * k) % 16;
         exp[8*k +: 4]     = 4'((lo + k) & 15);
         exp[8*k + 4 +: 4] = 4'((lo + 1 + k) & 15);
         drive_beat(d, lo, 0, k == 15);
         #1;
         checks++;
         if (bus.beat_ready !== 1'b1) begin
            errs++; $display("FAIL gat_rdy%0d got=%b exp=1", k, bus.beat_ready);
         end
         if (k == 15) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
               errs++; $display("FAIL gat_early got=%b exp=0", bus.out_valid);
            end
         end
      end
      @(negedge clk);
      idle_beat();
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
         errs++; $display("FAIL gat_data got=%b/%h exp=1/%h",
                          bus.out_valid, bus.out_data, exp);
      end
      checks++;
      if (bus.out_en !== 32'hFFFFFFFF || bus.out_last !== 1'b1) begin
         errs++; $display("FAIL gat_en got=%h/%b exp=ffffffff/1",
                          bus.out_en, bus.out_last);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errs++; $display("FAIL gat_drain got=%b exp=0", bus.out_valid);
      end
   endtask

   task automatic test_partial_reset();
      start_cmd(0, SEQ_SERIAL, 0);
      @(negedge clk);
      drive_beat(D0, 0, 5, 1'b1);
      #1;
      checks++;
      if (bus.beat_ready !== 1'b1) begin
         errs++; $display("FAIL part_rdy got=%b exp=1", bus.beat_ready);
      end
      @(negedge clk);
      idle_beat();
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== {108'h0, 20'h43210}) begin
         errs++; $display("FAIL part_data got=%b/%h exp=1/%h",
                          bus.out_valid, bus.out_data, {108'h0, 20'h43210});
      end
      checks++;
      if (bus.out_en !== 32'h0000001F || bus.out_last !== 1'b1) begin
         errs++; $display("FAIL part_en got=%h/%b exp=0000001f/1",
                          bus.out_en, bus.out_last);
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errs++; $display("FAIL part_idle got=%b exp=1", bus.cmd_ready);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      start_cmd(0, SEQ_SERIAL, 0);
      @(negedge clk);
      drive_beat(D0, 0, 16, 1'b0);
      @(negedge clk);
      drive_beat(D1, 0, 16, 1'b0);
      @(negedge clk);
      drive_beat(D0, 0, 16, 1'b0);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.beat_ready !== 1'b1) begin
         errs++; $display("FAIL part_midreq got=%b/%b exp=1/1",
                          bus.out_valid, bus.beat_ready);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.beat_ready !== 1'b0) begin
         errs++; $display("FAIL mrst_rdy got=%b/%b exp=1/0",
                          bus.cmd_ready, bus.beat_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
          bus.out_en !== '0 || bus.out_last !== 1'b0) begin
         errs++; $display("FAIL mrst_out got=%b/%h/%h/%b exp=0",
                          bus.out_valid, bus.out_data, bus.out_en, bus.out_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle_beat();
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         errs++; $display("FAIL mrst_after got=%b/%b exp=0/1",
                          bus.out_valid, bus.cmd_ready);
      end
   endtask

   initial begin
      errs   = 0;
      checks = 0;
      test_reset();
      test_serial();
      test_split();
      test_backpressure();
      test_gather();
      test_partial_reset();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/seq_load_packer.md
# seq_load_packer

Parametrised successor to the VLSU sequential-load data controller. It accepts AXI R-beat payloads plus per-beat nibble bounds and packs their valid nibbles into a `BufDepth`-deep FIFO of lane-entry buffers. Output goes to the shuffle unit. It supports serial (contiguous) and gather (one element per beat) commit modes, and splits beats across entry boundaries.

## Interface
- `BusNibbles`, 16: R-bus width in nibbles; power of 2, ≥4.
- `BufNibbles`, 32: entry width in nibbles (`(DLEN/4)*NrLanes`); power of 2, ≥ `BusNibbles`.
- `BufDepth`, 2: number of entries; power of 2, ≥2.
- `EewW`, 2: width of the element-size code.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `cmd_valid_i` in 1: request start is valid.
- `cmd_ready_o` out 1: request start is accepted.
- `cmd_ptr_i` in clog2(BufNibbles): starting nibble offset in the first entry.
- `cmd_mode_i` in 1: 0 = serial, 1 = gather.
- `cmd_eew_i` in EewW: gather element size is 2^eew nibbles.
- `beat_valid_i` in 1: beat is valid.
- `beat_ready_o` out 1: beat is accepted.
- `beat_data_i` in 4*BusNibbles: beat payload.
- `beat_lo_i` in clog2(BusNibbles): first valid nibble.
- `beat_hi_i` in clog2(BusNibbles)+1: one past the last valid nibble (serial mode only).
- `beat_last_i` in 1: final beat of the request.
- `out_valid_o` in/out: out 1: an entry is available.
- `out_ready_i` in 1: shuffle unit accepts the entry.
- `out_data_o` out 4*BufNibbles: entry nibbles.
- `out_en_o` out BufNibbles: per-nibble enable.
- `out_last_o` out 1: entry closes its request.

## Operation
- FSM states: IDLE and RUN.
  - IDLE→RUN on `cmd_valid_i`. `cmd_ready_o` = (state==IDLE). On transition, load `wr_ptr`←`cmd_ptr_i`, `bus_cnt`←0, and latch mode/eew.
  - RUN→IDLE in the cycle the last beat's final nibble is committed.
- Beat span per mode:
  - Serial: span = `beat_hi_i − beat_lo_i − bus_cnt`.
  - Gather: span = 2^eew − `bus_cnt`. `beat_hi_i` is ignored. `beat_lo_i + 2^eew ≤ BusNibbles` is guaranteed by the driver.
- Commit condition: RUN, `beat_valid_i`, and FIFO not full. A full FIFO blocks commit even when a dequeue occurs in the same cycle.
  - room = `BufNibbles − wr_ptr`.
  - n = min(span, room).
  - Nibbles `beat_lo_i+bus_cnt … +n−1` are written to working-entry slots `wr_ptr … wr_ptr+n−1`, and those `en` bits are set.
- If span > room:
  - Push the entry.
  - `wr_ptr`←0; `bus_cnt`+=n.
  - `beat_ready_o`=0.
- Otherwise:
  - `beat_ready_o`=1; `bus_cnt`←0; `wr_ptr`+=n.
  - Push when `wr_ptr+n == BufNibbles` or `beat_last_i`; in that case `wr_ptr`←0.
  - `out_last_o` of the pushed entry = `beat_last_i`.
- A zero-span beat is consumed in one cycle. If it is last, the working entry is pushed even when all `en` bits are 0.
- Arithmetic is unsigned at clog2(BufNibbles)+1 bits; no value wraps.
- Dequeue: `out_valid_o` = !empty. On `out_valid_o && out_ready_i`, the head entry is cleared to zero (data, en, last) and the read pointer advances.
- FIFO pointers carry a wrap flag:
  - full = equal index and differing flag.
  - empty = equal index and equal flag.
- Enqueue and dequeue may occur in the same cycle when the FIFO is not full.

## Timing
- Reset values: `cmd_ready_o`=1, `beat_ready_o`=0, `out_valid_o`=0, `out_data_o`/`out_en_o`/`out_last_o`=0.
  - All entries, pointers, `bus_cnt` and `wr_ptr` are 0; state is IDLE.
- Reset asserted mid-request discards all entries and partial state; no output is produced for that request.
- `beat_ready_o` is combinational from state, beat bounds and FIFO full.
  - It never depends on `out_ready_i` in the same cycle.
- Latency: a pushed entry shows `out_valid_o`=1 in the next cycle.
- Throughput: one beat per cycle while no split occurs; a split beat takes 2 cycles.
- The command for the next request may be accepted in the cycle after RUN→IDLE.

## Structure
- `vlsu_pkg` additions:
  - `seq_mode_e` {SEQ_SERIAL, SEQ_GATHER}.
  - `seq_entry_t` {nb, en, last}.
- Sub-module `seq_entry_fifo`: the `BufDepth`-entry storage, flagged pointers, and a write port for the working entry with a per-nibble mask plus push.
- The top level holds the FSM, span/room arithmetic and the nibble crossbar.

## Test plan
- Defaults, serial, ptr 0. Two beats lo=0/hi=16, second last → one entry, `en`=all ones, beat0 in slots 0–15, beat1 in slots 16–31, `out_last_o`=1. Each beat is readied in 1 cycle.
- Split across entries: ptr 24, beat lo=4/hi=16, last. Cycle 1 commits nibbles 4–11 into slots 24–31, pushes, `beat_ready_o`=0. Cycle 2 commits nibbles 12–15 into slots 0–3, `beat_ready_o`=1, pushes with `out_last_o`=1.
- Backpressure: `out_ready_i`=0 with 2 entries pushed → `beat_ready_o` stays 0 and the beat is held. Raise `out_ready_i` → head dequeues, commit resumes the following cycle, and the data matches the golden model.
- Gather: eew=1, 16 beats with lo=2k mod 16 → one entry. Slot pair 2k carries beat k's nibbles lo, lo+1; the push occurs on beat 16.
- Partial last plus reset: ptr 0, one beat lo=0/hi=5, last → `en`[4:0]=1 with the rest 0, `out_last_o`=1, IDLE next cycle. Then assert `rst_ni` mid-request → all outputs return to reset values.
